// File: rtl/cordic_gain_comp.sv
// CORDIC gain compensation: scales X/Y by 1/K with rounding and saturation,
// passes Z and mode through, and buffers results in a small output FIFO.
module cordic_gain_comp #(
    parameter int          N     = 32,
    parameter int          F     = 16,
    parameter int unsigned KINV  = 39797,
    parameter int          DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic signed [N-1:0]       in_x,
    input  logic signed [N-1:0]       in_y,
    input  logic signed [N-1:0]       in_z,
    input  logic                      in_mode,
    input  logic                      clear,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [N-1:0]       out_x,
    output logic signed [N-1:0]       out_y,
    output logic signed [N-1:0]       out_z,
    output logic                      out_mode,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic                      sat
);

    localparam int P  = N + F + 2;
    localparam int AW = $clog2(DEPTH);
    localparam logic signed [P-1:0] KS   = P'(KINV);
    localparam logic signed [P-1:0] RND  = {{(P-F){1'b0}}, 1'b1, {(F-1){1'b0}}};
    localparam logic signed [P-1:0] MAXV = {{(P-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [P-1:0] MINV = {{(P-N+1){1'b1}}, {(N-1){1'b0}}};
    localparam logic [AW:0]         FULL = (AW+1)'(DEPTH);

    // Returns {clipped, value}; rounding is half toward +infinity.
    function automatic logic [N:0] clip(input logic signed [P-1:0] p);
        logic signed [P-1:0] r;
        r = (p + RND) >>> F;
        if (r > MAXV)
            clip = {1'b1, MAXV[N-1:0]};
        else if (r < MINV)
            clip = {1'b1, MINV[N-1:0]};
        else
            clip = {1'b0, r[N-1:0]};
    endfunction

    logic                s1_v, s1_m;
    logic signed [P-1:0] s1_px, s1_py;
    logic [N-1:0]        s1_z;
    logic                s2_v, s2_m;
    logic [N-1:0]        s2_x, s2_y, s2_z;
    logic [N:0]          cx, cy;

    assign cx = clip(s1_px);
    assign cy = clip(s1_py);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            s1_v <= in_valid;
            s2_v <= s1_v;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            s1_px <= P'(in_x) * KS;
            s1_py <= P'(in_y) * KS;
            s1_z  <= in_z;
            s1_m  <= in_mode;
        end
        if (s1_v) begin
            s2_x <= cx[N-1:0];
            s2_y <= cy[N-1:0];
            s2_z <= s1_z;
            s2_m <= s1_m;
        end
    end

    logic [N-1:0]  mem_x [DEPTH];
    logic [N-1:0]  mem_y [DEPTH];
    logic [N-1:0]  mem_z [DEPTH];
    logic          mem_m [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic          empty, full, pop, wr_en, drop, sat_set;

    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL);
    assign pop     = !empty && out_ready;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign wr_en   = s2_v && (!full || pop);
    assign drop    = s2_v && full && !pop;
    assign sat_set = s1_v && (cx[N] || cy[N]);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_x[wr_ptr] <= s2_x;
            mem_y[wr_ptr] <= s2_y;
            mem_z[wr_ptr] <= s2_z;
            mem_m[wr_ptr] <= s2_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
            sat      <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({wr_en, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
            overflow <= drop || (overflow && !clear);
            sat      <= sat_set || (sat && !clear);
        end
    end

    assign count     = cnt;
    assign out_valid = !empty;
    assign out_x     = empty ? '0 : mem_x[rd_ptr];
    assign out_y     = empty ? '0 : mem_y[rd_ptr];
    assign out_z     = empty ? '0 : mem_z[rd_ptr];
    assign out_mode  = empty ? 1'b0 : mem_m[rd_ptr];

endmodule

// File: doc/cordic_gain_comp.md
CORDIC_GAIN_COMP -- requirements
Module: cordic_gain_comp

Interface
REQ-001 Parameter N, default 32: data width of X/Y/Z samples, signed two's complement.
REQ-002 Parameter F, default 16: fraction bits of the gain constant KINV.
REQ-003 Parameter KINV, default 39797: unsigned gain constant 1/K in Q(F), legal range 1..2^(F+1)-1.
REQ-004 Parameter DEPTH, default 4: output FIFO entries, power of two, minimum 2.
REQ-005 clk  in  1  clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 in_valid  in  1  upstream CORDIC done pulse; in_x/in_y/in_z/in_mode sampled when high.
REQ-008 in_x, in_y, in_z  in  N each  signed CORDIC results Xr/Yr/Zr.
REQ-009 in_mode  in  1  rot_vec of the sample, 0 rotation, 1 vectoring.
REQ-010 clear  in  1  synchronous clear of the sticky flags.
REQ-011 out_valid  out  1  FIFO head valid.
REQ-012 out_ready  in  1  downstream accepts the head when high with out_valid.
REQ-013 out_x, out_y, out_z  out  N each  gain-compensated X, Y, and pass-through Z.
REQ-014 out_mode  out  1  mode tag of the head entry.
REQ-015 count  out  clog2(DEPTH)+1  FIFO occupancy.
REQ-016 overflow  out  1  sticky; a sample was dropped.
REQ-017 sat  out  1  sticky; a result was saturated.

Function
REQ-018 The upstream interface shall have no backpressure; a sample is accepted on every clock edge where in_valid=1.
REQ-019 Stage 1 shall register px=in_x*KINV and py=in_y*KINV as full-precision signed products, plus in_z, in_mode and a valid bit.
REQ-020 Stage 2 shall compute (p + 2^(F-1)) >>> F arithmetically, rounding half toward +infinity.
REQ-021 Stage 2 shall saturate each result to [-2^(N-1), 2^(N-1)-1] and set sat when either X or Y clips.
REQ-022 Z and mode shall pass unmodified through both stages.
REQ-023 The stage 2 result shall be pushed into the FIFO on the next edge.
REQ-024 An in_valid sampled at edge E0 shall appear at the FIFO head after edge E2 when the FIFO was empty, giving a latency of 3 edges.
REQ-025 The pipeline shall accept back-to-back samples at 1 per clock with order preserved.
REQ-026 A pop shall occur on an edge where out_valid=1 and out_ready=1.
REQ-027 out_ready=1 while the FIFO is empty shall have no effect.
REQ-028 A push while full with no pop on the same edge shall drop the new entry, leave the FIFO contents unchanged and set overflow.
REQ-029 A push and a pop on the same edge while full shall both complete, with count unchanged and no overflow.
REQ-030 A push and a pop on the same edge at any other occupancy shall leave count unchanged.
REQ-031 Read and write pointers shall wrap modulo DEPTH, with full and empty derived from count.
REQ-032 out_x/out_y/out_z/out_mode shall be held stable while out_valid=1 and out_ready=0.
REQ-033 clear=1 shall zero overflow and sat on the next edge.
REQ-034 A flag-setting event on the same edge as clear shall take priority, leaving the flag at 1.
REQ-035 clear shall not affect the data path or the FIFO.

Reset
REQ-036 rst_n=0 shall immediately clear both stage valid bits, FIFO pointers and count, overflow, sat and out_valid.
REQ-037 rst_n=0 shall set out_x/out_y/out_z/out_mode to 0.
REQ-038 Reset mid-operation shall discard all in-flight and buffered samples without emitting any of them.
REQ-039 The first sample after rst_n deasserts shall be accepted on the first rising edge with in_valid=1.

Verification
REQ-040 Gain: in_x=65536, in_y=-65536, in_z=12345, out_ready=1 -> out_x=39797, out_y=-39797, out_z=12345 after 3 edges, count back to 0.
REQ-041 Rounding: KINV=32768, in_x=3 -> out_x=2; in_x=-3 -> out_x=-1.
REQ-042 Saturation: KINV=98304, in_x=0x7FFFFFFF, in_y=0x80000000 -> out_x=0x7FFFFFFF, out_y=0x80000000, sat=1 until clear.
REQ-043 Overflow: out_ready=0 with 6 consecutive in_valid -> count=4, overflow=1, then draining yields samples 1-4 in order.
REQ-044 Full with simultaneous push/pop: FIFO full, out_ready=1 and in_valid stream -> count stays 4, overflow stays 0, no sample lost.
REQ-045 Reset mid-stream: rst_n pulsed low with 2 samples in the pipeline and 3 in the FIFO -> out_valid=0 and count=0 immediately, nothing emitted afterwards.
